// File: rtl/peak_hold_ram_ctrl.sv
// Peak-hold level store on a single-port, registered-read RAM: samples raise an entry
// to the running maximum, readouts return one entry, decay ticks sweep every entry down.
module peak_hold_ram_ctrl #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CHANNELS    = 32,
  parameter int unsigned DECAY_SHIFT = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_valid,
  output logic                        sample_ready,
  input  logic [$clog2(CHANNELS)-1:0] sample_ch,
  input  logic [WIDTH-1:0]            sample_level,
  input  logic                        rd_req,
  output logic                        rd_ready,
  input  logic [$clog2(CHANNELS)-1:0] rd_ch,
  output logic                        rd_valid,
  output logic [WIDTH-1:0]            rd_level,
  input  logic                        decay_tick,
  output logic [$clog2(CHANNELS)-1:0] ram_addr,
  output logic                        ram_write_en,
  output logic [WIDTH-1:0]            ram_write_data,
  input  logic [WIDTH-1:0]            ram_read_data,
  output logic                        busy
);

  localparam int unsigned AW = $clog2(CHANNELS);
  localparam int unsigned IW = AW + 1;
  localparam logic [AW-1:0] LAST_CH  = AW'(CHANNELS - 1);
  localparam logic [IW-1:0] INIT_END = IW'(CHANNELS);

  typedef enum logic [2:0] {
    INIT, IDLE, S_RD, S_WR, R_RD, R_RSP, D_RD, D_WR
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    init_idx, init_idx_n;
  logic [AW-1:0]    sweep_idx, sweep_idx_n;
  logic             sweep_pend, sweep_pend_n;
  logic             resweep, resweep_n;
  logic [WIDTH-1:0] level_q, level_n;
  logic [AW-1:0]    addr_n;
  logic             we_n;
  logic             rd_valid_n;
  logic             sweep_end;
  logic [WIDTH-1:0] decay_step;
  logic [WIDTH-1:0] decay_val;
  logic [WIDTH-1:0] max_val;

  // Handshake and RAM control flops mirror the state they belong to, so reset forces them idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= INIT;
      init_idx     <= '0;
      sweep_idx    <= '0;
      sweep_pend   <= 1'b0;
      resweep      <= 1'b0;
      level_q      <= '0;
      ram_addr     <= '0;
      ram_write_en <= 1'b0;
      rd_valid     <= 1'b0;
      sample_ready <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_n;
      init_idx     <= init_idx_n;
      sweep_idx    <= sweep_idx_n;
      sweep_pend   <= sweep_pend_n;
      resweep      <= resweep_n;
      level_q      <= level_n;
      ram_addr     <= addr_n;
      ram_write_en <= we_n;
      rd_valid     <= rd_valid_n;
      sample_ready <= (state_n == IDLE);
      busy         <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n      = state;
    init_idx_n   = init_idx;
    sweep_idx_n  = sweep_idx;
    sweep_pend_n = sweep_pend;
    resweep_n    = resweep;
    level_n      = level_q;
    addr_n       = ram_addr;
    we_n         = 1'b0;
    rd_valid_n   = 1'b0;
    sweep_end    = 1'b0;

    case (state)
      INIT: begin
        if (init_idx == INIT_END) begin
          state_n = IDLE;
        end else begin
          we_n       = 1'b1;
          addr_n     = init_idx[AW-1:0];
          init_idx_n = init_idx + IW'(1);
        end
      end
      IDLE: begin
        if (sample_valid) begin
          state_n = S_RD;
          addr_n  = sample_ch;
          level_n = sample_level;
        end else if (rd_req) begin
          state_n = R_RD;
          addr_n  = rd_ch;
        end else if (sweep_pend) begin
          state_n = D_RD;
          addr_n  = sweep_idx;
        end
      end
      S_RD: begin
        state_n = S_WR;
        we_n    = 1'b1;
      end
      S_WR:  state_n = IDLE;
      R_RD: begin
        state_n    = R_RSP;
        rd_valid_n = 1'b1;
      end
      R_RSP: state_n = IDLE;
      D_RD: begin
        state_n = D_WR;
        we_n    = 1'b1;
      end
      D_WR: begin
        state_n = IDLE;
        if (sweep_idx == LAST_CH) sweep_end = 1'b1;
        else                      sweep_idx_n = sweep_idx + AW'(1);
      end
      default: state_n = INIT;
    endcase

    // A tick landing on the final step counts as the coalesced re-sweep request.
    if (sweep_end) begin
      if (resweep || decay_tick) begin
        sweep_idx_n = '0;
        resweep_n   = 1'b0;
      end else begin
        sweep_pend_n = 1'b0;
      end
    end else if (decay_tick) begin
      if (!sweep_pend) begin
        sweep_pend_n = 1'b1;
        sweep_idx_n  = '0;
      end else begin
        resweep_n = 1'b1;
      end
    end
  end

  // Write data needs the RAM word that arrives in the write cycle itself.
  always_comb begin
    decay_step = ram_read_data >> DECAY_SHIFT;
    if (decay_step == '0) decay_step = WIDTH'(1);
    decay_val = (ram_read_data == '0) ? '0 : ram_read_data - decay_step;
    max_val   = (ram_read_data > level_q) ? ram_read_data : level_q;

    ram_write_data = '0;
    case (state)
      S_WR:    ram_write_data = max_val;
      D_WR:    ram_write_data = decay_val;
      default: ram_write_data = '0;
    endcase

    rd_level = (state == R_RSP) ? ram_read_data : '0;
  end

  assign rd_ready = sample_ready & ~sample_valid;

endmodule

// File: tb/tb_peak_hold_ram_ctrl.sv
// Directed bench for peak_hold_ram_ctrl: a level-array model with sweep bookkeeping checks
// every RAM write and readout, plus literal expectations for the worked scenarios.
module tb_peak_hold_ram_ctrl;

  localparam int unsigned W  = 16;
  localparam int unsigned CH = 32;
  localparam int unsigned AW = 5;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          sample_valid = 1'b0;
  logic          sample_ready;
  logic [AW-1:0] sample_ch = '0;
  logic [W-1:0]  sample_level = '0;
  logic          rd_req = 1'b0;
  logic          rd_ready;
  logic [AW-1:0] rd_ch = '0;
  logic          rd_valid;
  logic [W-1:0]  rd_level;
  logic          decay_tick = 1'b0;
  logic [AW-1:0] ram_addr;
  logic          ram_write_en;
  logic [W-1:0]  ram_write_data;
  logic [W-1:0]  ram_read_data = '0;
  logic          busy;
  logic          scrub = 1'b1;

  int checks = 0;
  int failures = 0;

  peak_hold_ram_ctrl #(.WIDTH(W), .CHANNELS(CH), .DECAY_SHIFT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_ch(sample_ch), .sample_level(sample_level),
    .rd_req(rd_req), .rd_ready(rd_ready), .rd_ch(rd_ch),
    .rd_valid(rd_valid), .rd_level(rd_level),
    .decay_tick(decay_tick),
    .ram_addr(ram_addr), .ram_write_en(ram_write_en),
    .ram_write_data(ram_write_data), .ram_read_data(ram_read_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered, read-first output; scrub fills it with junk at start.
  logic [W-1:0] mem [CH];
  always @(posedge clk) begin
    if (scrub) begin
      for (int i = 0; i < CH; i++) mem[i] <= 16'hA5A5;
    end else if (ram_write_en) begin
      mem[ram_addr] <= ram_write_data;
    end
    ram_read_data <= mem[ram_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  function automatic int unsigned decayed(input int unsigned v);
    int unsigned step;
    if (v == 0) return 0;
    step = v / 16;
    if (step < 1) step = 1;
    return v - step;
  endfunction

  // Model state: expected entry contents, one outstanding op of each kind, sweep bookkeeping.
  int unsigned lvl_model [CH];
  bit          s_pend, r_pend;
  int unsigned s_ch, s_lvl, r_ch;
  int          s_cyc, r_cyc;
  int unsigned sweeps_left = 0;
  int unsigned sw_idx = 0;
  int unsigned dwr_count = 0;
  int          cyc = 0;

  always @(negedge clk) begin : compare
    int unsigned exp_v;
    bit wc, rc;
    if (!reset_n) begin
      check("reset_outputs",
            64'({ram_write_en, ram_addr, ram_write_data, sample_ready, rd_ready,
                 rd_valid, rd_level, busy}),
            64'({1'b0, 5'd0, 16'd0, 1'b0, 1'b0, 1'b0, 16'd0, 1'b1}));
      for (int i = 0; i < CH; i++) lvl_model[i] = 0;
      s_pend = 0; r_pend = 0; sweeps_left = 0; sw_idx = 0; cyc = 0;
    end else begin
      if (cyc == 0) begin
        check("init_first_idle", 64'(ram_write_en), 64'(0));
      end else if (cyc <= CH) begin
        check("init_we", 64'(ram_write_en), 64'(1));
        check("init_addr", 64'(ram_addr), 64'(cyc - 1));
        check("init_data", 64'(ram_write_data), 64'(0));
        check("init_handshake", 64'({sample_ready, rd_ready, busy}), 64'(3'b001));
      end
      if (cyc == CH + 1) check("ready_after_init", 64'(sample_ready), 64'(1));
      if (cyc > CH) begin
        wc = 0; rc = 0;
        if (decay_tick) begin
          if (sweeps_left == 0) begin sweeps_left = 1; sw_idx = 0; end
          else if (sweeps_left == 1) sweeps_left = 2;
        end
        check("rd_ready_rule", 64'(rd_ready), 64'(sample_ready && !sample_valid));
        check("busy_rule", 64'(busy), 64'(!sample_ready));
        if (s_pend && cyc == s_cyc + 2) begin
          exp_v = (lvl_model[s_ch] > s_lvl) ? lvl_model[s_ch] : s_lvl;
          check("sample_we", 64'(ram_write_en), 64'(1));
          check("sample_addr", 64'(ram_addr), 64'(s_ch));
          check("sample_data", 64'(ram_write_data), 64'(exp_v));
          lvl_model[s_ch] = exp_v;
          s_pend = 0; wc = 1;
        end
        if (r_pend && cyc == r_cyc + 2) begin
          check("rd_valid_pulse", 64'(rd_valid), 64'(1));
          check("rd_level_model", 64'(rd_level), 64'(lvl_model[r_ch]));
          r_pend = 0; rc = 1;
        end
        if (ram_write_en && !wc) begin
          if (sweeps_left > 0 && !s_pend && !r_pend) begin
            exp_v = decayed(lvl_model[sw_idx]);
            check("decay_addr", 64'(ram_addr), 64'(sw_idx));
            check("decay_data", 64'(ram_write_data), 64'(exp_v));
            lvl_model[sw_idx] = exp_v;
            dwr_count++;
            sw_idx++;
            if (sw_idx == CH) begin sw_idx = 0; sweeps_left--; end
          end else begin
            check("unexpected_write", 64'(ram_write_en), 64'(0));
          end
        end
        if (rd_valid && !rc) check("unexpected_rd_valid", 64'(rd_valid), 64'(0));
        if (sample_valid && sample_ready) begin
          s_pend = 1; s_ch = sample_ch; s_lvl = sample_level; s_cyc = cyc;
        end
        if (rd_req && rd_ready) begin
          r_pend = 1; r_ch = rd_ch; r_cyc = cyc;
        end
      end
      cyc++;
    end
  end

  task automatic do_sample(input int unsigned ch, input int unsigned lvl);
    int n = 0;
    @(posedge clk); #1;
    sample_valid = 1'b1; sample_ch = AW'(ch); sample_level = W'(lvl);
    @(negedge clk);
    while (!sample_ready && n < 200) begin n++; @(negedge clk); end
    check("sample_accepted", 64'(sample_ready), 64'(1));
    @(posedge clk); #1;
    sample_valid = 1'b0; sample_ch = ~AW'(ch); sample_level = ~W'(lvl);
  endtask

  task automatic do_read(input int unsigned ch, input int unsigned exp);
    int n = 0;
    @(posedge clk); #1;
    rd_req = 1'b1; rd_ch = AW'(ch);
    @(negedge clk);
    while (!rd_ready && n < 200) begin n++; @(negedge clk); end
    check("read_accepted", 64'(rd_ready), 64'(1));
    @(posedge clk); #1;
    rd_req = 1'b0; rd_ch = ~AW'(ch);
    n = 0;
    @(negedge clk);
    while (!rd_valid && n < 20) begin n++; @(negedge clk); end
    check("read_valid_seen", 64'(rd_valid), 64'(1));
    check("read_level_lit", 64'(rd_level), 64'(exp));
  endtask

  task automatic pulse_tick();
    @(posedge clk); #1 decay_tick = 1'b1;
    @(posedge clk); #1 decay_tick = 1'b0;
  endtask

  task automatic wait_sweep_done();
    int n = 0;
    while (sweeps_left != 0 && n < 3000) begin n++; @(negedge clk); end
    check("sweep_complete", 64'(sweeps_left), 64'(0));
    repeat (6) @(negedge clk);
  endtask

  task automatic check_ram_cleared();
    int nz = 0;
    for (int i = 0; i < CH; i++) if (mem[i] != '0) nz++;
    check("ram_cleared", 64'(nz), 64'(0));
  endtask

  initial begin : stim
    int unsigned start;
    int n;
    repeat (3) @(posedge clk);
    #1 scrub = 1'b0; reset_n = 1'b1;
    repeat (CH + 4) @(posedge clk);
    check_ram_cleared();

    // Peak hold keeps the larger sample.
    do_sample(3, 16'h0100);
    do_sample(3, 16'h0080);
    do_read(3, 16'h0100);

    // One sweep: 0x100 -> 0xF0, 1 -> 0, 0 stays 0.
    do_sample(5, 16'h0100);
    do_sample(6, 16'h0001);
    pulse_tick();
    wait_sweep_done();
    do_read(5, 16'h00F0);
    do_read(6, 16'h0000);
    do_read(7, 16'h0000);
    do_read(3, 16'h00F0);

    // Three ticks in one sweep coalesce into exactly two sweeps.
    start = dwr_count;
    pulse_tick();
    repeat (5) @(posedge clk);
    pulse_tick();
    repeat (20) @(posedge clk);
    pulse_tick();
    wait_sweep_done();
    check("two_sweeps_writes", 64'(dwr_count - start), 64'(64));
    do_read(5, 16'h00D3);

    // Sample and readout requests held through a sweep.
    pulse_tick();
    for (int i = 0; i < 24; i++) begin
      @(posedge clk); #1;
      sample_valid = 1'b1; sample_ch = AW'(10 + i % 4); sample_level = W'(i * 40 + 3);
      rd_req = 1'b1; rd_ch = AW'(12);
    end
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      sample_valid = 1'b0; rd_req = 1'b1; rd_ch = AW'(10 + i % 4);
    end
    @(posedge clk); #1 rd_req = 1'b0;
    wait_sweep_done();

    // Reset during the sample write: the write is dropped and INIT repeats.
    @(posedge clk); #1;
    sample_valid = 1'b1; sample_ch = AW'(9); sample_level = W'(16'h0055);
    n = 0;
    @(negedge clk);
    while (!sample_ready && n < 200) begin n++; @(negedge clk); end
    check("reset_sample_accepted", 64'(sample_ready), 64'(1));
    @(posedge clk); #1 sample_valid = 1'b0;
    @(posedge clk); #2 reset_n = 1'b0;
    #1 check("we_dropped_in_reset", 64'(ram_write_en), 64'(0));
    @(posedge clk); #1 check("no_write_in_reset", 64'(mem[9]), 64'(0));
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (CH + 4) @(posedge clk);
    check_ram_cleared();
    do_sample(9, 16'h0042);
    do_read(9, 16'h0042);

    repeat (5) @(negedge clk);
    check("nothing_outstanding", 64'({s_pend, r_pend}), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/peak_hold_ram_ctrl.md
PEAK_HOLD_RAM_CTRL -- requirements
Module: peak_hold_ram_ctrl

Interface
REQ-001 Parameter WIDTH, default 16, bit width of one level value.
REQ-002 Parameter CHANNELS, default 32, number of level entries; address width AW = $clog2(CHANNELS).
REQ-003 Parameter DECAY_SHIFT, default 4, right-shift applied to an entry to form its decay step.
REQ-004 clk  in  1  sole clock; all logic on posedge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 sample_valid  in  1  new level sample offered.
REQ-007 sample_ready  out  1  controller accepts a sample this cycle.
REQ-008 sample_ch  in  AW  target entry of the sample.
REQ-009 sample_level  in  WIDTH  unsigned magnitude of the sample.
REQ-010 rd_req  in  1  display readout request.
REQ-011 rd_ready  out  1  controller accepts a readout this cycle.
REQ-012 rd_ch  in  AW  entry to read.
REQ-013 rd_valid  out  1  one-cycle pulse; rd_level holds the result.
REQ-014 rd_level  out  WIDTH  returned entry value.
REQ-015 decay_tick  in  1  one-cycle pulse requesting a decay sweep of all entries.
REQ-016 ram_addr  out  AW  to the single-port RAM address.
REQ-017 ram_write_en  out  1  to the RAM write enable.
REQ-018 ram_write_data  out  WIDTH  to the RAM write data.
REQ-019 ram_read_data  in  WIDTH  from the RAM; valid one cycle after ram_addr is presented (registered read).
REQ-020 busy  out  1  high in any state other than IDLE.

Function
REQ-021 The FSM SHALL have states INIT, IDLE, S_RD, S_WR, R_RD, R_RSP, D_RD, D_WR.
REQ-022 INIT SHALL write 0 to addresses 0..CHANNELS-1, one per cycle in ascending order, then enter IDLE; sample_ready and rd_ready SHALL be 0 throughout INIT.
REQ-023 sample_ready SHALL be 1 only in IDLE; rd_ready SHALL be 1 only in IDLE when sample_valid is 0.
REQ-024 IDLE priority SHALL be: accepted sample, then accepted readout, then pending sweep step.
REQ-025 Sample path: S_RD presents the latched sample_ch; S_WR writes max(ram_read_data, latched sample_level) to the same address; then IDLE (2 cycles per sample).
REQ-026 Readout path: R_RD presents rd_ch; R_RSP drives rd_level = ram_read_data with rd_valid = 1 for exactly that cycle; then IDLE.
REQ-027 A decay_tick SHALL set a sweep-pending flag and reset the sweep index to 0 when no sweep is active; a tick during an active sweep SHALL set one coalesced re-sweep flag, and further ticks SHALL be dropped.
REQ-028 Sweep step: D_RD presents the sweep index; D_WR writes v - max(v>>DECAY_SHIFT, 1) for v != 0, and 0 for v == 0, with no underflow.
REQ-029 After each sweep step the FSM SHALL return to IDLE so that samples and readouts interleave per entry; after index CHANNELS-1 the sweep SHALL end, restarting at 0 if the re-sweep flag is set (flag cleared).
REQ-030 ram_write_en SHALL be 1 only in INIT, S_WR and D_WR; ram_addr SHALL be held stable across each RD/WR pair.
REQ-031 Inputs SHALL be latched at acceptance; changes to sample_ch, sample_level or rd_ch after acceptance SHALL NOT affect the operation in progress.

Reset
REQ-032 While reset_n = 0: state = INIT, init index = 0, sample_ready = 0, rd_ready = 0, rd_valid = 0, rd_level = 0, ram_write_en = 0, ram_addr = 0, ram_write_data = 0, busy = 1, and sweep and re-sweep flags cleared.
REQ-033 Reset asserted mid-operation SHALL abandon the operation; after release the full INIT clear SHALL repeat.

Verification
REQ-034 Release reset, CHANNELS=32 -> 32 cycles with ram_write_en=1 at addresses 0..31 and data 0; sample_ready rises on cycle 33.
REQ-035 Samples ch3=0x0100, then ch3=0x0080, then readout ch3 -> rd_valid with rd_level=0x0100.
REQ-036 ch5=0x0100, one decay_tick, readout ch5 after the sweep -> 0x00F0; ch6=0x0001 after the same sweep -> 0x0000; 0 entries stay 0.
REQ-037 3 decay_ticks within one sweep -> exactly two full sweeps, 64 D_WR writes total.
REQ-038 sample_valid and rd_req both held continuously during a sweep -> each IDLE visit serves the sample first, rd_ready=0 while sample_valid=1, the sweep still completes, and no write is lost.
REQ-039 Assert reset_n=0 during S_WR -> no write occurs that cycle, and the INIT clear repeats after release.
